// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Integer-truncated system clocks per serial bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver host-side bundle: serial line in, byte/valid/ready handshake and status flags out.
// Optional parity_err flag is present when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 ready;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (input rx, ready,
                  output dout, valid, rx_busy, frame_err, overrun, parity_err);
  modport slave  (output rx, ready,
                  input dout, valid, rx_busy, frame_err, overrun, parity_err);
`else
  modport master (input rx, ready,
                  output dout, valid, rx_busy, frame_err, overrun);
  modport slave  (output rx, ready,
                  input dout, valid, rx_busy, frame_err, overrun);
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial line, push keys).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability chain; both stages reset to the line's idle level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with one-entry valid/ready holding register and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic      clock,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic xfer_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (bus.rx),
    .q_o     (rx_s)
  );

  assign xfer_s = valid_q & bus.ready;

  // Next-state, bit assembly and holding-register/flag update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = perr_q;
`endif

    if (xfer_s) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          pbad_d  = (^shift_q) ^ rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          ferr_d  = ferr_d | ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = perr_d | pbad_q;
`endif
          // An unconsumed byte wins; the new one is dropped and flagged.
          if (valid_q && !bus.ready) begin
            ovr_d = 1'b1;
          end else begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default 50 MHz / 115200 baud; table vectors plus scoreboard.
module tb_uart_rx;

  localparam int CPB = 50000000 / 115200;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[6];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    bus.rx = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // Drives one frame; a bad stop bit is low for 3/4 bit then released high.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                            input logic push);
    if (push) exp_q.push_back('{data: d, perr: bad_par});
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ bad_par);
`endif
    if (stop) begin
      bit_time(1'b1);
    end else begin
      bus.rx = 1'b0;
      repeat (CPB * 3 / 4) @(posedge clock);
      #1;
      bus.rx = 1'b1;
      repeat (CPB - CPB * 3 / 4) @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (bus.valid !== 1'b1 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({name, "_valid"}, bus.valid, 1'b1);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    chk({name, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({name, "_dout"}, bus.dout, e.data);
`ifdef UART_RX_PARITY_EN
      chk({name, "_parity_err"}, bus.parity_err, e.perr);
`endif
    end
  endtask

  task automatic ack();
    bus.ready = 1'b1;
    @(posedge clock);
    #1;
    bus.ready = 1'b0;
  endtask

  initial begin
    int n;
    int lat;
    logic vseen;

    tbl[0] = '{data: 8'h55, stop: 1'b1, exp_ferr: 1'b0};
    tbl[1] = '{data: 8'hA3, stop: 1'b1, exp_ferr: 1'b0};
    tbl[2] = '{data: 8'h3C, stop: 1'b1, exp_ferr: 1'b0};
    tbl[3] = '{data: 8'h0F, stop: 1'b0, exp_ferr: 1'b1};
    tbl[4] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
    tbl[5] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b0};

    bus.rx = 1'b1;
    bus.ready = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_busy", bus.rx_busy, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_ovr", bus.overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr", bus.parity_err, 1'b0);
`endif
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // 0x55 with latency measurement, then held with ready low.
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      begin
        while (bus.valid !== 1'b1 && lat < LAT + 500) begin
          @(posedge clock);
          #1;
          lat++;
        end
      end
    join
    chk("lat_55_in_range", (lat >= LAT - 1) && (lat <= LAT + 2), 1'b1);
    wait_valid("hold55", 10);
    check_pop("hold55");
    chk("hold55_ferr", bus.frame_err, 1'b0);
    chk("hold55_ovr", bus.overrun, 1'b0);
    repeat (2000) @(posedge clock);
    #1;
    chk("hold55_dout_stable", bus.dout, 8'h55);
    chk("hold55_valid_stable", bus.valid, 1'b1);
    ack();
    chk("hold55_valid_clr", bus.valid, 1'b0);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, 1'b0, 1'b1);
      wait_valid("tbl", 600);
      check_pop("tbl");
      chk("tbl_ferr", bus.frame_err, tbl[i].exp_ferr);
      chk("tbl_ovr", bus.overrun, 1'b0);
      ack();
      chk("tbl_valid_clr", bus.valid, 1'b0);
      chk("tbl_ferr_clr", bus.frame_err, 1'b0);
      repeat (20) @(posedge clock);
      #1;
    end

    // Back-to-back frames, acked as each byte appears.
    fork
      begin
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_valid("b2b", 9000);
          check_pop("b2b");
          chk("b2b_ferr", bus.frame_err, 1'b0);
          chk("b2b_ovr", bus.overrun, 1'b0);
          ack();
        end
      end
    join
    repeat (20) @(posedge clock);
    #1;

    // Start-bit glitch: 100 cycles low is rejected at mid start bit.
    n = 0;
    vseen = 1'b0;
    bus.rx = 1'b0;
    fork
      begin
        repeat (100) @(posedge clock);
        #1;
        bus.rx = 1'b1;
      end
      begin
        repeat (400) begin
          @(posedge clock);
          #1;
          if (bus.rx_busy) n++;
          if (bus.valid) vseen = 1'b1;
        end
      end
    join
    chk("glitch_busy_len_ok", (n >= 210) && (n <= 225), 1'b1);
    chk("glitch_no_valid", vseen, 1'b0);
    chk("glitch_idle", bus.rx_busy, 1'b0);
    chk("glitch_flags", {bus.frame_err, bus.overrun}, 2'b00);

    // Overrun: second byte arrives while the first is unconsumed.
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    wait_valid("ovr1", 10);
    chk("ovr1_no_ovr", bus.overrun, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr2_flag", bus.overrun, 1'b1);
    chk("ovr2_valid", bus.valid, 1'b1);
    check_pop("ovr2");
    ack();
    chk("ovr_valid_clr", bus.valid, 1'b0);
    chk("ovr_flag_clr", bus.overrun, 1'b0);
    repeat (20) @(posedge clock);
    #1;

    // Reset in the middle of bit 4 of 0xFF.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    repeat (100) @(posedge clock);
    #1;
    chk("abort_busy_before", bus.rx_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy_rst", bus.rx_busy, 1'b0);
    chk("abort_valid_rst", bus.valid, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (CPB * 5) @(posedge clock);
    #1;
    chk("abort_no_valid", bus.valid, 1'b0);
    chk("abort_no_flags", {bus.frame_err, bus.overrun}, 2'b00);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    wait_valid("post_abort", 600);
    check_pop("post_abort");
    chk("post_abort_ferr", bus.frame_err, 1'b0);
    ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    wait_valid("par", 600);
    check_pop("par");
    ack();
    chk("par_clr", bus.parity_err, 1'b0);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first. It is the receive-side counterpart of the existing uart transmitter.
- Samples the asynchronous rx line on the 50 MHz system clock and assembles each frame into a byte.
- Presents the byte through a one-entry valid/ready holding register to a host FSM, e.g. a command decoder that starts TRNG capture from a PC instead of KEY[0].
- Flags framing and overrun errors.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- DATA_BITS, 8, payload bits per frame.

Ports:
- clock  input  1  system clock (CLOCK_50).
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- dout  output  DATA_BITS  received byte; stable while valid=1.
- valid  output  1  dout holds an unconsumed byte.
- ready  input  1  host accepts; the transfer completes on a cycle with valid&ready.
- rx_busy  output  1  frame reception in progress (state != IDLE).
- frame_err  output  1  sticky; stop bit sampled low. Cleared by a valid&ready transfer.
- overrun  output  1  sticky; a new byte completed while valid=1. Cleared by a valid&ready transfer.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; dout=0, valid=0, rx_busy=0, frame_err=0, overrun=0; both synchronizer flops=1; baud counter and bit index=0.
- rx passes through a 2-flop synchronizer, all logic uses rx_s. This adds 2 cycles of input latency.
- Baud counter width is $clog2(CLKS_PER_BIT). The counter reloads to 0 on every state transition.
- IDLE: on rx_s=0 -> START, counter=0.
- START: at count CLKS_PER_BIT/2-1 (mid start bit):
  - rx_s=0 -> DATA, bit index=0.
  - rx_s=1 -> IDLE (glitch rejected; no flags, no output).
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[index] (LSB first).
  - After index DATA_BITS-1 is sampled -> STOP (or PARITY when the option is enabled).
- STOP: after CLKS_PER_BIT cycles, sample rx_s. On the next edge:
  - dout <= shift and valid <= 1, whether or not the stop bit is good.
  - frame_err |= ~rx_s.
  - If valid was already 1 and not consumed this cycle: keep the old dout, drop the new byte, set overrun=1.
  - Then -> IDLE.
- Latency: valid rises (2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT) cycles after the falling start edge at the pin, ±1.
- Handshake:
  - valid&ready -> valid<=0, frame_err<=0, overrun<=0.
  - If completion and a valid&ready transfer fall in the same cycle, the new byte loads (valid stays 1) and neither byte is lost.
  - ready while valid=0 is ignored.
- Back-to-back frames: a start bit directly after the stop-bit sample is detected, because IDLE is re-entered half a bit early.
- rx held low (break): the frame completes with frame_err=1. The FSM then returns to IDLE, immediately sees rx_s=0, re-enters START, and repeats until the line goes high.
- Reset mid-frame aborts immediately: the partial byte is discarded and no flags are set.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, one bit time long, even parity.
  - Adds output parity_err (1 bit, sticky, reset 0), set when XOR(shift, parity bit)=1 and cleared by a valid&ready transfer.
  - The byte is still delivered.
  - Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum logic [2:0] {IDLE, START, DATA, PARITY, STOP}.
  - Function clks_per_bit(clk_freq, baud).
  - Constant UART_DATA_BITS=8.
  - Shared with the transmitter.
- Sub-module sync_2ff (parameter RESET_VAL=1): a two-flop synchronizer, also reusable for KEY inputs.

Test Plan:
- Reset, then 0x55 at 115200 baud with stop=1 -> valid rises once, dout=0x55, frame_err=0, overrun=0. Hold ready=0 and dout stays 0x55.
- 0xA3 then 0x3C back-to-back, ready pulsed after each valid -> 0xA3 then 0x3C in order, no flags.
- rx low for 100 cycles then high -> returns to IDLE, valid stays 0, rx_busy=1 only for ~219 cycles.
- 0x0F with stop bit driven 0 -> dout=0x0F, valid=1, frame_err=1. A valid&ready transfer clears frame_err.
- 0x11 then 0x22 with ready=0 throughout -> dout=0x11, overrun=1. Assert ready -> valid=0, overrun=0.
- reset_n pulsed low during bit 4 of 0xFF, then 0x81 sent -> no byte from the aborted frame, dout=0x81. With UART_RX_PARITY_EN, 0x81 with parity bit 1 -> parity_err=1.
